// File: rtl/mem_wb_multi_pkg.sv
// Shared constants and control types for the multi-lane MEM->WB pipeline register.
package mem_wb_multi_pkg;

  localparam logic STOP         = 1'b1;
  localparam logic NOSTOP       = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned REG_DATA_W    = 32;
  localparam int unsigned DEFAULT_LANES = 2;

  localparam logic [REG_ADDR_W-1:0] NOPRegAddr = '0;
  localparam logic [REG_DATA_W-1:0] ZeroWord   = '0;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2
  } lane_act_e;

  // Flush beats everything; a self-stall with a free WB stage drains a bubble.
  function automatic lane_act_e decode_act(input logic flush,
                                           input logic stall_self,
                                           input logic stall_next);
    if (flush)
      return ACT_BUBBLE;
    else if (stall_self == STOP && stall_next == NOSTOP)
      return ACT_BUBBLE;
    else if (stall_self == STOP)
      return ACT_HOLD;
    else
      return ACT_LOAD;
  endfunction

endpackage

// File: rtl/wb_lane_reg.sv
// One write-back lane register: load, bubble or hold each cycle.
module wb_lane_reg
  import mem_wb_multi_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  lane_act_e         act,
  input  logic              ld_wreg,
  input  logic [ADDR_W-1:0] ld_waddr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              wb_wreg,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata
);

  always_ff @(posedge clk) begin
    if (rst || act == ACT_BUBBLE) begin
      wb_wreg  <= WriteDisable;
      wb_waddr <= ADDR_W'(NOPRegAddr);
      wb_wdata <= DATA_W'(ZeroWord);
    end else if (act == ACT_LOAD) begin
      wb_wreg  <= ld_wreg;
      wb_waddr <= ld_waddr;
      wb_wdata <= ld_wdata;
    end
  end

endmodule

// File: rtl/mem_wb_multi.sv
// Multi-lane MEM->WB pipeline register with x0/same-address sanitising and a retired-write counter.
module mem_wb_multi
  import mem_wb_multi_pkg::*;
#(
  parameter int unsigned LANES  = DEFAULT_LANES,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_self,
  input  logic                      stall_next,
  input  logic                      flush,
  input  logic [LANES-1:0]          mem_wreg,
  input  logic [LANES*ADDR_W-1:0]   mem_waddr,
  input  logic [LANES*DATA_W-1:0]   mem_wdata,
  output logic [LANES-1:0]          wb_wreg,
  output logic [LANES*ADDR_W-1:0]   wb_waddr,
  output logic [LANES*DATA_W-1:0]   wb_wdata,
  output logic [CNT_W-1:0]          retire_cnt
);

  localparam int unsigned PC_W = $clog2(LANES + 1);

  lane_act_e                      act;
  logic [LANES-1:0][LANES-1:0]    conf;
  logic [LANES-1:0]               san_wreg;
  logic [LANES*ADDR_W-1:0]        san_waddr;
  logic [LANES*DATA_W-1:0]        san_wdata;
  logic [PC_W-1:0]                pc;

  assign act = decode_act(flush, stall_self, stall_next);

  // conf[i][j]: a younger lane j writes the same nonzero register as lane i.
  for (genvar i = 0; i < LANES; i++) begin : g_conf_i
    for (genvar j = 0; j < LANES; j++) begin : g_conf_j
      if (j > i) begin : g_younger
        assign conf[i][j] = mem_wreg[j]
                         && (mem_waddr[j*ADDR_W +: ADDR_W] == mem_waddr[i*ADDR_W +: ADDR_W])
                         && (mem_waddr[i*ADDR_W +: ADDR_W] != '0);
      end else begin : g_older
        assign conf[i][j] = 1'b0;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic en;
    assign en = mem_wreg[i] && (mem_waddr[i*ADDR_W +: ADDR_W] != '0) && !(|conf[i]);
    assign san_wreg[i] = en ? WriteEnable : WriteDisable;
    assign san_waddr[i*ADDR_W +: ADDR_W] = en ? mem_waddr[i*ADDR_W +: ADDR_W] : ADDR_W'(NOPRegAddr);
    assign san_wdata[i*DATA_W +: DATA_W] = en ? mem_wdata[i*DATA_W +: DATA_W] : DATA_W'(ZeroWord);

    wb_lane_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .act      (act),
      .ld_wreg  (san_wreg[i]),
      .ld_waddr (san_waddr[i*ADDR_W +: ADDR_W]),
      .ld_wdata (san_wdata[i*DATA_W +: DATA_W]),
      .wb_wreg  (wb_wreg[i]),
      .wb_waddr (wb_waddr[i*ADDR_W +: ADDR_W]),
      .wb_wdata (wb_wdata[i*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    pc = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      pc = pc + PC_W'(san_wreg[k]);
    end
  end

  // Wraps modulo 2^CNT_W; only loads are counted.
  always_ff @(posedge clk) begin
    if (rst)
      retire_cnt <= '0;
    else if (act == ACT_LOAD)
      retire_cnt <= retire_cnt + CNT_W'(pc);
  end

endmodule

// File: tb/tb_mem_wb_multi.sv
// Table-driven scoreboard bench for mem_wb_multi: 2-lane/32-bit, 2-lane/4-bit counter and 1-lane builds.
module tb_mem_wb_multi;

  logic        clk = 1'b0;
  logic        rst, stall_self, stall_next, flush;
  logic [1:0]  mem_wreg;
  logic [9:0]  mem_waddr;
  logic [63:0] mem_wdata;

  logic [1:0]  wb_wreg,  ww_wreg;
  logic [9:0]  wb_waddr, ww_waddr;
  logic [63:0] wb_wdata, ww_wdata;
  logic [31:0] retire_cnt;
  logic [3:0]  ww_cnt;

  logic        w1_wreg;
  logic [4:0]  w1_waddr;
  logic [31:0] w1_wdata;
  logic [31:0] w1_cnt;

  always #5 clk = ~clk;

  mem_wb_multi #(.LANES(2), .ADDR_W(5), .DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall_self(stall_self), .stall_next(stall_next), .flush(flush),
    .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_wreg(wb_wreg), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .retire_cnt(retire_cnt));

  mem_wb_multi #(.LANES(2), .ADDR_W(5), .DATA_W(32), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .stall_self(stall_self), .stall_next(stall_next), .flush(flush),
    .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_wreg(ww_wreg), .wb_waddr(ww_waddr), .wb_wdata(ww_wdata), .retire_cnt(ww_cnt));

  mem_wb_multi #(.LANES(1), .ADDR_W(5), .DATA_W(32), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .stall_self(stall_self), .stall_next(stall_next), .flush(flush),
    .mem_wreg(mem_wreg[0]), .mem_waddr(mem_waddr[4:0]), .mem_wdata(mem_wdata[31:0]),
    .wb_wreg(w1_wreg), .wb_waddr(w1_waddr), .wb_wdata(w1_wdata), .retire_cnt(w1_cnt));

  typedef struct {
    logic        rst, flush, ss, sn;
    logic [1:0]  wreg;
    logic [9:0]  addr;
    logic [63:0] data;
    logic [1:0]  ew;
    logic [9:0]  ea;
    logic [63:0] ed;
    logic [31:0] ec;
  } vec_t;

  typedef struct {
    logic [1:0]  w;
    logic [9:0]  a;
    logic [63:0] d;
    logic [31:0] c;
    logic [3:0]  cw;
    logic        w1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [31:0] c1;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Single-lane reference state
  logic        m1_w;
  logic [4:0]  m1_a;
  logic [31:0] m1_d;
  logic [31:0] m1_c = '0;

  function automatic vec_t mk(input logic r, input logic f, input logic s, input logic n,
                              input logic [1:0] w, input logic [4:0] a1, input logic [4:0] a0,
                              input logic [31:0] d1, input logic [31:0] d0,
                              input logic [1:0] ew, input logic [4:0] ea1, input logic [4:0] ea0,
                              input logic [31:0] ed1, input logic [31:0] ed0, input logic [31:0] ec);
    vec_t v;
    v.rst = r; v.flush = f; v.ss = s; v.sn = n;
    v.wreg = w; v.addr = {a1, a0}; v.data = {d1, d0};
    v.ew = ew; v.ea = {ea1, ea0}; v.ed = {ed1, ed0}; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    logic en;
    rst = v.rst; flush = v.flush; stall_self = v.ss; stall_next = v.sn;
    mem_wreg = v.wreg; mem_waddr = v.addr; mem_wdata = v.data;
    if (v.rst) begin
      m1_w = 1'b0; m1_a = '0; m1_d = '0; m1_c = '0;
    end else if (v.flush || (v.ss && !v.sn)) begin
      m1_w = 1'b0; m1_a = '0; m1_d = '0;
    end else if (!v.ss) begin
      en   = v.wreg[0] && (v.addr[4:0] != 5'd0);
      m1_w = en;
      m1_a = en ? v.addr[4:0] : 5'd0;
      m1_d = en ? v.data[31:0] : 32'd0;
      m1_c = m1_c + 32'(en);
    end
    e.w = v.ew; e.a = v.ea; e.d = v.ed; e.c = v.ec; e.cw = v.ec[3:0];
    e.w1 = m1_w; e.a1 = m1_a; e.d1 = m1_d; e.c1 = m1_c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s scoreboard: got empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " wreg"},  64'(wb_wreg),    64'(e.w));
      chk({tag, " waddr"}, 64'(wb_waddr),   64'(e.a));
      chk({tag, " wdata"}, wb_wdata,        e.d);
      chk({tag, " cnt"},   64'(retire_cnt), 64'(e.c));
      chk({tag, " cnt4"},  64'(ww_cnt),     64'(e.cw));
      chk({tag, " l1 wreg"},  64'(w1_wreg),  64'(e.w1));
      chk({tag, " l1 waddr"}, 64'(w1_waddr), 64'(e.a1));
      chk({tag, " l1 wdata"}, 64'(w1_wdata), 64'(e.d1));
      chk({tag, " l1 cnt"},   64'(w1_cnt),   64'(e.c1));
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall_self = 1'b0; stall_next = 1'b0;
    mem_wreg = '0; mem_waddr = '0; mem_wdata = '0;

    // Reset with random payloads, then release into a full bundle
    tbl.push_back(mk(1,0,0,0, 2'b11, 5'd7, 5'd3, $urandom, $urandom, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1,1,1,0, 2'(2'($urandom)), 5'(5'($urandom)), 5'd2, $urandom, $urandom, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,0,0, 2'b11, 5'd7, 5'd3, 32'h12345678, 32'hAAAA5555,
                     2'b11, 5'd7, 5'd3, 32'h12345678, 32'hAAAA5555, 2));
    // Load ignores stall_next; disabled lane1 is zeroed
    tbl.push_back(mk(0,0,0,1, 2'b01, 5'd5, 5'd4, 32'h99, 32'h11, 2'b01, 0, 5'd4, 0, 32'h11, 3));
    // Hold for three cycles while inputs change
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,0,1,1, 2'b11, 5'(8 + k), 5'(12 + k), 32'(k), 32'(k + 100),
                       2'b01, 0, 5'd4, 0, 32'h11, 3));
    tbl.push_back(mk(0,0,1,0, 2'b11, 5'd8, 5'd9, 32'h1, 32'h2, 2'b00, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0,1,0,0, 2'b01, 5'd0, 5'd5, 32'h0, 32'hFF, 2'b00, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0,0,0,0, 2'b11, 5'd10, 5'd6, 32'h77, 32'h66, 2'b11, 5'd10, 5'd6, 32'h77, 32'h66, 5));
    // Flush during a hold request writes a bubble
    tbl.push_back(mk(0,1,1,1, 2'b11, 5'd12, 5'd13, 32'h1, 32'h2, 2'b00, 0, 0, 0, 0, 5));
    // x0 suppression
    tbl.push_back(mk(0,0,0,0, 2'b11, 5'd9, 5'd0, 32'h1, 32'hDEAD, 2'b10, 5'd9, 0, 32'h1, 0, 6));
    // Same-address conflict: lane1 wins
    tbl.push_back(mk(0,0,0,0, 2'b11, 5'd9, 5'd9, 32'h3, 32'h2, 2'b10, 5'd9, 0, 32'h3, 0, 7));
    // Same address but younger lane disabled: no conflict
    tbl.push_back(mk(0,0,0,0, 2'b01, 5'd9, 5'd9, 32'h44, 32'h55, 2'b01, 0, 5'd9, 0, 32'h55, 8));
    // Reset during a hold
    tbl.push_back(mk(1,0,1,1, 2'b11, 5'd1, 5'd2, 32'h5, 32'h6, 2'b00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0,0,0,0, 2'b11, 5'd0, 5'd2, 32'h6, 32'h5, 2'b01, 0, 5'd2, 0, 32'h5, 1));
    // Counter wrap: fresh reset then nine double-write loads
    tbl.push_back(mk(1,0,0,0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(0,0,0,0, 2'b11, 5'(k + 10), 5'(k), 32'(k * 3), 32'(k * 5),
                       2'b11, 5'(k + 10), 5'(k), 32'(k * 3), 32'(k * 5), 32'(2 * k)));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("row%0d", i));

    // Release after hold loads the current bundle, not the held one
    apply(mk(0,0,0,0, 2'b11, 5'd20, 5'd21, 32'hA, 32'hB, 2'b11, 5'd20, 5'd21, 32'hA, 32'hB, 20), "rel0");
    apply(mk(0,0,1,1, 2'b11, 5'd22, 5'd23, 32'hC, 32'hD, 2'b11, 5'd20, 5'd21, 32'hA, 32'hB, 20), "rel1");
    apply(mk(0,0,1,1, 2'b01, 5'd26, 5'd27, 32'hC, 32'hD, 2'b11, 5'd20, 5'd21, 32'hA, 32'hB, 20), "rel2");
    apply(mk(0,0,0,1, 2'b11, 5'd24, 5'd25, 32'hE, 32'hF, 2'b11, 5'd24, 5'd25, 32'hE, 32'hF, 22), "rel3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
